// File: rtl/iitb_risc_pkg.sv
// Shared datapath sizes and MEM-stage sequencer state encoding.
package iitb_risc_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int NREG      = 8;
    localparam int REG_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } mem_state_t;
endpackage

// File: rtl/lsb_pri_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, plus presence flags.
module lsb_pri_enc
    import iitb_risc_pkg::*;
(
    input  logic [NREG-1:0]      mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 any,
    output logic                 more_than_one
);
    always_comb begin
        idx = '0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) idx = REG_IDX_W'(i);
        end
    end

    assign any           = |mask;
    assign more_than_one = |(mask & (mask - NREG'(1)));
endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives data memory for LW/SW and serialises LM/SM into one
// register transfer per cycle, stalling upstream until the last transfer.
module mem_stage
    import iitb_risc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    alu_result_exmem,
    input  logic [DATA_W-1:0]    wrdata_exmem,
    input  logic                 memread_exmem,
    input  logic                 memwrite_exmem,
    input  logic                 lm_exmem,
    input  logic                 sm_exmem,
    input  logic [NREG-1:0]      regmask_exmem,
    input  logic [REG_IDX_W-1:0] regdst_exmem,
    input  logic                 regwrite_exmem,
    input  logic                 memtoreg_exmem,
    input  logic [15:0]          pc_exmem,
    input  logic [1:0]           prev_cz_exmem,
    input  logic [1:0]           cz_exmem,
    input  logic [3:0]           aluop_exmem,
    input  logic [1:0]           irlast_exmem,
    input  logic [15:0]          imm9_0_pad_exmem,
    output logic [15:0]          pc_mem,
    output logic [1:0]           prev_cz_mem,
    output logic [1:0]           cz_mem,
    output logic [3:0]           aluop_mem,
    output logic [1:0]           irlast_mem,
    output logic [15:0]          imm9_0_pad_mem,
    output logic [REG_IDX_W-1:0] sm_rd_addr,
    input  logic [DATA_W-1:0]    sm_rd_data,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    output logic                 dmem_we,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic [DATA_W-1:0]    alu_result_mem,
    output logic [DATA_W-1:0]    memrd_data_mem,
    output logic [REG_IDX_W-1:0] regdst_mem,
    output logic                 regwrite_mem,
    output logic                 memtoreg_mem,
    output logic                 mem_stall
);
    // Stall contract: while mem_stall=1 the EX/MEM register and every earlier
    // stage hold their contents, so all *_exmem inputs stay stable until the
    // cycle in which mem_stall drops; that cycle's outputs complete the instruction.

    mem_state_t          state, state_nx;
    logic [NREG-1:0]     rem_mask, rem_mask_nx;
    logic [ADDR_W-1:0]   cur_addr, cur_addr_nx;

    logic [NREG-1:0]      m;
    logic [ADDR_W-1:0]    a;
    logic [REG_IDX_W-1:0] idx;
    logic                 any_bit, multi_bit;
    logic                 is_lm;

    assign m = (state == IDLE) ? regmask_exmem : rem_mask;
    assign a = (state == IDLE) ? alu_result_exmem[ADDR_W-1:0] : cur_addr;
    // Opcode kind comes from the held EX/MEM register; lm wins if both are set.
    assign is_lm = lm_exmem;

    lsb_pri_enc u_enc (
        .mask          (m),
        .idx           (idx),
        .any           (any_bit),
        .more_than_one (multi_bit)
    );

    assign pc_mem         = pc_exmem;
    assign prev_cz_mem    = prev_cz_exmem;
    assign cz_mem         = cz_exmem;
    assign aluop_mem      = aluop_exmem;
    assign irlast_mem     = irlast_exmem;
    assign imm9_0_pad_mem = imm9_0_pad_exmem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rem_mask <= '0;
            cur_addr <= '0;
        end else begin
            state    <= state_nx;
            rem_mask <= rem_mask_nx;
            cur_addr <= cur_addr_nx;
        end
    end

    always_comb begin
        state_nx       = IDLE;
        rem_mask_nx    = '0;
        cur_addr_nx    = cur_addr;
        sm_rd_addr     = '0;
        dmem_addr      = alu_result_exmem[ADDR_W-1:0];
        dmem_wdata     = wrdata_exmem;
        dmem_we        = memwrite_exmem;
        memrd_data_mem = dmem_rdata;
        alu_result_mem = alu_result_exmem;
        regdst_mem     = regdst_exmem;
        regwrite_mem   = regwrite_exmem;
        memtoreg_mem   = memtoreg_exmem;
        mem_stall      = 1'b0;

        if (state == MULTI || lm_exmem || sm_exmem) begin
            if (!any_bit) begin
                dmem_we      = 1'b0;
                regwrite_mem = 1'b0;
                memtoreg_mem = 1'b0;
            end else begin
                dmem_addr      = a;
                alu_result_mem = DATA_W'(a);
                if (is_lm) begin
                    dmem_we      = 1'b0;
                    regdst_mem   = idx;
                    regwrite_mem = 1'b1;
                    memtoreg_mem = 1'b1;
                end else begin
                    sm_rd_addr   = idx;
                    dmem_wdata   = sm_rd_data;
                    dmem_we      = 1'b1;
                    regwrite_mem = 1'b0;
                    memtoreg_mem = 1'b0;
                end
                if (multi_bit) begin
                    mem_stall   = 1'b1;
                    state_nx    = MULTI;
                    rem_mask_nx = m & ~(NREG'(1) << idx);
                    cur_addr_nx = a + ADDR_W'(1);
                end
            end
        end

        // Reset aborts any sequence and suppresses side effects this cycle.
        if (reset) begin
            dmem_we      = 1'b0;
            regwrite_mem = 1'b0;
            mem_stall    = 1'b0;
        end
    end
endmodule
